seq_addsub: RTL and testbench

Parametrised, multi-cycle integer adder/subtractor for the FPU datapath (mantissa subtract/restore steps in the FP divider and future FP add path). Processes a WIDTH-bit operation as WIDTH/CHUNK ripple slices, one slice per clock, with the inter-slice carry held in a register. This bounds the carry chain to CHUNK bits per cycle. Adds a reverse-subtract and pass mode, signed-overflow and zero flags, and valid/ready handshakes on both sides.

---
 rtl/seq_addsub_pkg.sv | 20 ++
 rtl/seq_addsub_if.sv | 37 +++
 rtl/seq_addsub_chunk.sv | 49 ++++
 rtl/seq_addsub.sv | 176 +++++++++++++++++
 tb/tb_seq_addsub.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_addsub_pkg.sv
// ----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the sequential adder/subtractor:
//   - operation encodings carried on the op bus (ADD, SUB, RSUB, PASS)
//   - FSM state encoding used by seq_addsub
// ----------------------------------------------------------------------------
package addsub_pkg;

   localparam logic [1:0] ADD  = 2'b00;  // a + b
   localparam logic [1:0] SUB  = 2'b01;  // a - b
   localparam logic [1:0] RSUB = 2'b10;  // b - a
   localparam logic [1:0] PASS = 2'b11;  // a + 0

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage : addsub_pkg

// File: rtl/seq_addsub_if.sv
// ----------------------------------------------------------------------------
// seq_addsub_if
// Operand and result handshake bundle for seq_addsub.
//   in_valid/in_ready   : operand-side handshake (producer -> block)
//   a, b, op            : operands and operation select
//   out_valid/out_ready : result-side handshake (block -> consumer)
//   res, cout, ovf, zero: result and flags
// Modports:
//   slave  : the arithmetic block
//   master : the producer/consumer environment
// ----------------------------------------------------------------------------
interface seq_addsub_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, res, cout, ovf, zero
   );

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, res, cout, ovf, zero
   );

endinterface : seq_addsub_if

// File: rtl/seq_addsub_chunk.sv
// ----------------------------------------------------------------------------
// full_adder   : single-bit full adder cell.
// addsub_chunk : combinational CHUNK-bit ripple slice built from full_adder.
//   x_i, y_i   : slice operands (y already inverted for subtraction)
//   cin_i      : carry into the slice LSB
//   sum_o      : slice sum
//   cout_o     : carry out of the slice MSB
//   c_msb_in_o : carry into the slice MSB (overflow detection on top slice)
// ----------------------------------------------------------------------------
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule : full_adder

module addsub_chunk #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] x_i,
   input  logic [CHUNK-1:0] y_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o,
   output logic             c_msb_in_o
);
   // c_s[i] is the carry into bit i; c_s[CHUNK] leaves the slice.
   logic [CHUNK:0] c_s;

   assign c_s[0] = cin_i;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .a_i  (x_i[i]),
         .b_i  (y_i[i]),
         .ci_i (c_s[i]),
         .s_o  (sum_o[i]),
         .co_o (c_s[i+1])
      );
   end

   assign cout_o     = c_s[CHUNK];
   assign c_msb_in_o = c_s[CHUNK-1];

endmodule : addsub_chunk

// File: rtl/seq_addsub.sv
// ----------------------------------------------------------------------------
// seq_addsub
// Multi-cycle WIDTH-bit adder/subtractor. The operation is split into
// NCHUNK = WIDTH/CHUNK slices, one slice per clock, with the inter-slice
// carry held in a register so the combinational carry chain is CHUNK bits.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_addsub_if.slave (operand/result handshakes, result, flags)
// Latency is NCHUNK cycles from the acceptance edge to out_valid; no
// overlap between consecutive operations.
// ----------------------------------------------------------------------------
module seq_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_addsub_if.slave   bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_addsub: WIDTH must be a multiple of CHUNK");
   end

   // Operands and result are held as arrays of slices so the active slice
   // can be selected and written back by slice index directly.
   typedef logic [NCHUNK-1:0][CHUNK-1:0] slices_t;

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   slices_t       x_q, x_d;
   slices_t       y_q, y_d;
   slices_t       res_q, res_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;
   logic          zero_q, zero_d;

   logic [CHUNK-1:0] sum_s;
   logic             sl_cout_s;
   logic             sl_cmsb_s;

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x_i        (x_q[k_q]),
      .y_i        (y_q[k_q]),
      .cin_i      (carry_q),
      .sum_o      (sum_s),
      .cout_o     (sl_cout_s),
      .c_msb_in_o (sl_cmsb_s)
   );

   // Next-state, operand mapping, slice write-back and flag computation.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      x_d     = x_q;
      y_d     = y_q;
      res_d   = res_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = S_RUN;
               k_d     = '0;
               res_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               zero_d  = 1'b0;
               // Subtraction is x + ~y + 1; rsub swaps the operand roles.
               case (bus.op)
                  ADD: begin
                     x_d     = bus.a;
                     y_d     = bus.b;
                     carry_d = 1'b0;
                  end
                  SUB: begin
                     x_d     = bus.a;
                     y_d     = ~bus.b;
                     carry_d = 1'b1;
                  end
                  RSUB: begin
                     x_d     = bus.b;
                     y_d     = ~bus.a;
                     carry_d = 1'b1;
                  end
                  PASS: begin
                     x_d     = bus.a;
                     y_d     = '0;
                     carry_d = 1'b0;
                  end
                  default: begin
                     x_d     = bus.a;
                     y_d     = '0;
                     carry_d = 1'b0;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            res_d[k_q] = sum_s;
            carry_d    = sl_cout_s;
            if (k_q == K_LAST) begin
               state_d = S_DONE;
               k_d     = '0;
               cout_d  = sl_cout_s;
               // On the top slice the slice-MSB carry-in is the carry into bit WIDTH-1.
               ovf_d   = sl_cmsb_s ^ sl_cout_s;
               // Zero is taken over the complete result including the slice just written.
               zero_d  = (res_d == '0);
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, operand, carry, result and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_q     <= x_d;
         y_q     <= y_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   // Handshake outputs decode state only; data outputs come straight from registers.
   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.res       = res_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

endmodule : seq_addsub

// File: tb/tb_seq_addsub.sv
// Directed-vector bench for seq_addsub: a 64/16 instance driven from a
// vector table plus backpressure and reset sequences, and a 32/8 instance.
module tb_seq_addsub;
   import addsub_pkg::*;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   seq_addsub_if #(.WIDTH(64)) ifc0 ();
   seq_addsub_if #(.WIDTH(32)) ifc1 ();

   seq_addsub #(.WIDTH(64), .CHUNK(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
   seq_addsub #(.WIDTH(32), .CHUNK(8))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Present an operation on ifc0, wait for acceptance, scramble the inputs,
   // and count edges from the acceptance edge until out_valid.
   task automatic do_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int lat);
      int guard;
      @(negedge clk);
      ifc0.in_valid = 1'b1;
      ifc0.a = a;
      ifc0.b = b;
      ifc0.op = op;
      guard = 0;
      while (!ifc0.in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      ifc0.in_valid = 1'b0;
      ifc0.a = ~a;
      ifc0.b = ~b;
      ifc0.op = ~op;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!ifc0.out_valid && lat < 20);
   endtask

   task automatic ack0();
      @(negedge clk);
      ifc0.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc0.out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      n_pass = 0;
      n_total = 0;

      vecs[0]  = '{ADD,  64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{SUB,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{SUB,  64'h1234, 64'h1234, 64'h0, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{SUB,  64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{RSUB, 64'd3, 64'd10, 64'd7, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{PASS, 64'hDEAD_BEEF, 64'h5555, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{ADD,  64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{RSUB, 64'd10, 64'd3, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{PASS, 64'h0, 64'hFFFF, 64'h0, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{ADD,  64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      ifc0.in_valid = 1'b0; ifc0.a = '0; ifc0.b = '0; ifc0.op = ADD; ifc0.out_ready = 1'b0;
      ifc1.in_valid = 1'b0; ifc1.a = '0; ifc1.b = '0; ifc1.op = ADD; ifc1.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      chk("rst_in_ready", 64'(ifc0.in_ready), 64'd1);
      chk("rst_out_valid", 64'(ifc0.out_valid), 64'd0);
      chk("rst_res", ifc0.res, 64'd0);
      chk("rst_flags", {61'd0, ifc0.cout, ifc0.ovf, ifc0.zero}, 64'd0);

      // Vector table
      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
         chk($sformatf("v%0d_res", i), ifc0.res, vecs[i].res);
         chk($sformatf("v%0d_cout", i), 64'(ifc0.cout), 64'(vecs[i].cout));
         chk($sformatf("v%0d_ovf", i), 64'(ifc0.ovf), 64'(vecs[i].ovf));
         chk($sformatf("v%0d_zero", i), 64'(ifc0.zero), 64'(vecs[i].zero));
         chk($sformatf("v%0d_in_ready_busy", i), 64'(ifc0.in_ready), 64'd0);
         ack0();
         chk($sformatf("v%0d_in_ready_after", i), 64'(ifc0.in_ready), 64'd1);
         chk($sformatf("v%0d_out_valid_after", i), 64'(ifc0.out_valid), 64'd0);
      end

      // Backpressure: hold DONE for 5 cycles with a second request pending
      do_op(ADD, 64'd100, 64'd23, lat);
      chk("bp_first_res", ifc0.res, 64'd123);
      @(negedge clk);
      ifc0.in_valid = 1'b1;
      ifc0.a = 64'd10;
      ifc0.b = 64'd20;
      ifc0.op = ADD;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold%0d_res", c), ifc0.res, 64'd123);
         chk($sformatf("bp_hold%0d_out_valid", c), 64'(ifc0.out_valid), 64'd1);
         chk($sformatf("bp_hold%0d_in_ready", c), 64'(ifc0.in_ready), 64'd0);
      end
      ack0();
      chk("bp_hs_in_ready", 64'(ifc0.in_ready), 64'd1);
      chk("bp_hs_out_valid", 64'(ifc0.out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("bp_second_accepted", 64'(ifc0.in_ready), 64'd0);
      ifc0.in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!ifc0.out_valid && lat < 20);
      chk("bp_second_latency", 64'(lat), 64'd4);
      chk("bp_second_res", ifc0.res, 64'd30);
      ack0();

      // Reset in the middle of RUN after two slices
      @(negedge clk);
      ifc0.in_valid = 1'b1;
      ifc0.a = 64'h0003_0003_0003_0003;
      ifc0.b = 64'd1;
      ifc0.op = ADD;
      chk("mr_idle_before", 64'(ifc0.in_ready), 64'd1);
      @(posedge clk);
      #1;
      ifc0.in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("mr_partial_res", ifc0.res, 64'h0000_0000_0003_0004);
      rst_n = 1'b0;
      #1;
      chk("mr_out_valid", 64'(ifc0.out_valid), 64'd0);
      chk("mr_res", ifc0.res, 64'd0);
      chk("mr_flags", {61'd0, ifc0.cout, ifc0.ovf, ifc0.zero}, 64'd0);
      chk("mr_in_ready", 64'(ifc0.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(ADD, 64'd1, 64'd1, lat);
      chk("mr_after_latency", 64'(lat), 64'd4);
      chk("mr_after_res", ifc0.res, 64'd2);
      ack0();

      // 32-bit / 8-bit instance: all-ones plus one wraps to zero
      @(negedge clk);
      ifc1.in_valid = 1'b1;
      ifc1.a = 32'hFFFF_FFFF;
      ifc1.b = 32'h1;
      ifc1.op = ADD;
      chk("w32_in_ready", 64'(ifc1.in_ready), 64'd1);
      @(posedge clk);
      #1;
      ifc1.in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!ifc1.out_valid && lat < 20);
      chk("w32_latency", 64'(lat), 64'd4);
      chk("w32_res", 64'(ifc1.res), 64'd0);
      chk("w32_cout", 64'(ifc1.cout), 64'd1);
      chk("w32_ovf", 64'(ifc1.ovf), 64'd0);
      chk("w32_zero", 64'(ifc1.zero), 64'd1);
      @(negedge clk);
      ifc1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc1.out_ready = 1'b0;
      chk("w32_in_ready_after", 64'(ifc1.in_ready), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_seq_addsub
